// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the architectural HI/LO
// register pair. MULT/MULTU/DIV/DIVU run one bit per clock (WIDTH edges in
// CALC plus one FIX edge); MTHI/MTLO complete in a single idle cycle.
// WIDTH must be even and >= 4; CNT_W must satisfy 2**CNT_W > WIDTH.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  // FSM state
  state_t r_state;
  state_t w_state_nxt;

  // Latched operation context
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;    // 1 = divide, 0 = multiply
  logic               r_neg_q;     // product / quotient must be negated
  logic               r_neg_r;     // remainder must be negated (dividend < 0)
  logic               r_dz_pend;   // divide by zero detected at accept
  logic [WIDTH-1:0]   r_a_raw;     // raw dividend, returned in HI on div-by-zero
  logic [WIDTH-1:0]   r_opnd;      // |multiplicand| or |divisor|
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {remainder, dividend bits shifting into the quotient}.
  logic [2*WIDTH-1:0] r_acc;

  // Control decode
  logic w_load;       // accept a mul/div start
  logic w_mthi;       // accept MTHI
  logic w_mtlo;       // accept MTLO
  logic w_calc;       // iteration edge
  logic w_fix;        // result write-back edge

  // Operand preparation
  logic             w_signed;
  logic             w_op_div;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  // Iteration datapath
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_nxt;

  // Result correction
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !op[2]) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == '0)     w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: busy and per-edge datapath enables
  always_comb begin
    busy   = 1'b0;
    w_load = 1'b0;
    w_mthi = 1'b0;
    w_mtlo = 1'b0;
    w_calc = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load = start && !op[2];
        w_mthi = start && (op == OP_MTHI);
        w_mtlo = start && (op == OP_MTLO);
      end
      S_CALC: begin
        busy   = 1'b1;
        w_calc = 1'b1;
      end
      S_FIX: begin
        busy  = 1'b1;
        w_fix = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Operand sign handling: op[0]=0 selects the signed variants
  always_comb begin
    w_signed = ~op[0];
    w_op_div = op[1];
    w_a_neg  = w_signed & a[WIDTH-1];
    w_b_neg  = w_signed & b[WIDTH-1];
    w_abs_a  = w_a_neg ? -a : a;
    w_abs_b  = w_b_neg ? -b : b;
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole register right.
    w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_nxt = {w_add, r_acc[WIDTH-1:1]};
    // Divide: shift the next dividend bit into the remainder; subtract the
    // divisor when it fits. The remainder stays below the divisor, so the
    // difference always fits in WIDTH bits.
    w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_opnd});
    w_diff    = w_rem_sh[WIDTH-1:0] - r_opnd;
    w_div_nxt = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
  end

  // Sign correction of the magnitude results. The most-negative / -1 case
  // needs no special handling: the magnitude quotient 2**(WIDTH-1) is left
  // un-negated (both operands negative) and reads back as the most-negative
  // value with a zero remainder.
  always_comb begin
    w_prod_fix = r_neg_q ? -r_acc : r_acc;
    w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  // Operation context and iteration registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz_pend <= 1'b0;
      r_a_raw   <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
    end else if (w_load) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_cnt     <= CNT_W'(WIDTH - 1);
      r_is_div  <= w_op_div;
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_dz_pend <= w_op_div && (b == '0);
      r_a_raw   <= a;
      r_opnd    <= w_op_div ? w_abs_b : w_abs_a;
      r_acc     <= {{WIDTH{1'b0}}, (w_op_div ? w_abs_a : w_abs_b)};
    end else if (w_calc) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
    end
  end

  // Architectural HI/LO, done pulse and divide-by-zero flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      dz   <= 1'b0;
    end else begin
      done <= w_fix;
      if (w_load || w_mthi || w_mtlo) dz <= 1'b0;
      if (w_mthi) hi <= a;
      if (w_mtlo) lo <= a;
      if (w_fix) begin
        if (!r_is_div) begin
          hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          lo <= w_prod_fix[WIDTH-1:0];
        end else if (r_dz_pend) begin
          hi <= r_a_raw;
          lo <= '1;
          dz <= 1'b1;
        end else begin
          hi <= w_rem_fix;
          lo <= w_quo_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit (WIDTH=32).
// Stimulus pushes the hand-computed HI/LO/dz result of each mul/div into a
// queue; a monitor pops and compares whenever done pulses, and also checks
// that busy stayed high for exactly WIDTH+1 cycles before it.
module tb_muldiv_unit;

  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  typedef struct {
    string      name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic       dz;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt = 0;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each completed result against the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          check({e.name, "_dz"}, 64'(dz), 64'(e.dz));
          check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
        end
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end
    end
  end

  always @(negedge rst_n) busy_cnt = 0;

  // Drive one start; caller is positioned just after a negedge
  task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] h,
                               input logic [W-1:0] l, input logic z);
    exp_t e;
    e.name = name;
    e.hi   = h;
    e.lo   = l;
    e.dz   = z;
    sb.push_back(e);
  endtask

  // Return at the negedge where done is high (bounded)
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz",   64'(dz),   64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULT -3*5, with an MTLO and operand changes while busy
    expect_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    repeat (5) @(negedge clk);
    issue(OP_MTLO, 32'hDEAD_BEEF, 32'h1234_5678);
    a = 32'h0BAD_F00D;
    b = 32'h7777_7777;
    wait_done("mult_neg");
    @(negedge clk);
    check("mtlo_busy_ignored_lo", 64'(lo), 64'h0000_0000_FFFF_FFF1);

    expect_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max");

    // Back-to-back: each following start is issued in the done cycle
    expect_result("mult_m1m1", 32'h0000_0000, 32'h0000_0001, 1'b0);
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mult_m1m1");

    expect_result("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div_neg7_2");

    expect_result("divu_100_7", 32'h0000_0002, 32'h0000_000E, 1'b0);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done("divu_100_7");

    expect_result("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf");

    expect_result("divu_zero", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    issue(OP_DIVU, 32'h1234_5678, 32'h0000_0000);
    wait_done("divu_zero");

    // Next accepted start clears dz
    expect_result("multu_7_6", 32'h0000_0000, 32'h0000_002A, 1'b0);
    issue(OP_MULTU, 32'd7, 32'd6);
    check("dz_cleared_on_start", 64'(dz), 64'd0);
    wait_done("multu_7_6");

    // MTHI while idle: single edge, no busy, no done
    issue(OP_MTHI, 32'hAAAA_5555, 32'h0);
    check("mthi_hi",   64'(hi),   64'h0000_0000_AAAA_5555);
    check("mthi_lo",   64'(lo),   64'h0000_0000_0000_002A);
    check("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("mthi_done", 64'(done), 64'd0);
    check("mthi_busy2", 64'(busy), 64'd0);

    // Reserved op is a no-op
    issue(OP_NOP, 32'h5555_5555, 32'h1);
    @(negedge clk);
    check("nop_busy", 64'(busy), 64'd0);
    check("nop_hi",   64'(hi),   64'h0000_0000_AAAA_5555);
    check("nop_lo",   64'(lo),   64'h0000_0000_0000_002A);

    // Asynchronous reset in the middle of a DIV; no result is expected
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    repeat (10) @(negedge clk);
    check("div_busy_before_rst", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi",   64'(hi),   64'd0);
    check("arst_lo",   64'(lo),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    expect_result("multu_3_4", 32'h0000_0000, 32'h0000_000C, 1'b0);
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done("multu_3_4");

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
